// File: rtl/sfp_prbs_checker.sv
// PRBS31 receive checker for the SFP0 GTH RX user interface.
// Self-synchronises to the incoming pattern, then counts bit/word errors and lock losses.
module sfp_prbs_checker #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PRBS_LEN   = 31,
  parameter int unsigned PRBS_TAP   = 28,
  parameter int unsigned LOCK_CNT   = 64,
  parameter int unsigned UNLOCK_ERR = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              clr_cnt,
  output logic              locked,
  output logic              err_word,
  output logic [CNT_W-1:0]  bit_err_cnt,
  output logic [CNT_W-1:0]  word_err_cnt,
  output logic [15:0]       lock_loss_cnt
);

  localparam int unsigned EW  = $clog2(DATA_W + 1);
  localparam int unsigned VW  = $clog2(LOCK_CNT + 1);
  localparam int unsigned CW  = $clog2(UNLOCK_ERR + 1);
  localparam int unsigned GAP = PRBS_LEN - PRBS_TAP;

  typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

  state_e                state_q, state_d;
  logic [PRBS_LEN-1:0]   hist_q, hist_d;
  logic [VW-1:0]         vcnt_q, vcnt_d;
  logic [CW-1:0]         ccnt_q, ccnt_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      bit_q, bit_d;
  logic [CNT_W-1:0]      word_q, word_d;
  logic [15:0]           loss_q, loss_d;

  logic [DATA_W-1:0]     pred;
  logic [DATA_W-1:0]     diff;
  logic [PRBS_LEN-1:0]   gen_h;
  logic [PRBS_LEN-1:0]   seed;
  logic [EW-1:0]         ecnt;
  logic [EW-1:0]         e_eff;
  logic                  seed_ok;
  logic                  err_hit;
  logic                  unlock;
  logic [CNT_W:0]        bit_sum;

  // hist[0] is the oldest bit; each step emits b[n] = b[n-LEN] ^ b[n-TAP].
  // gen_h ends up holding the history advanced by one full word.
  always_comb begin
    gen_h = hist_q;
    pred  = '0;
    for (int i = 0; i < DATA_W; i++) begin
      pred[i] = gen_h[0] ^ gen_h[GAP];
      gen_h   = {pred[i], gen_h[PRBS_LEN-1:1]};
    end
  end

  assign seed    = rx_data[DATA_W-1 -: PRBS_LEN];
  assign seed_ok = |rx_data;
  assign diff    = rx_data ^ pred;

  always_comb begin
    ecnt = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ecnt = ecnt + EW'(diff[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    vcnt_d  = vcnt_q;
    ccnt_d  = ccnt_q;
    err_d   = 1'b0;
    err_hit = 1'b0;
    unlock  = 1'b0;
    if (rx_valid) begin
      unique case (state_q)
        StSearch: begin
          if (seed_ok) begin
            hist_d  = seed;
            vcnt_d  = '0;
            state_d = StVerify;
          end
        end
        StVerify: begin
          if (rx_data == pred) begin
            hist_d = gen_h;
            if (vcnt_q == VW'(LOCK_CNT - 1)) begin
              state_d = StLocked;
              vcnt_d  = '0;
              ccnt_d  = '0;
            end else begin
              vcnt_d = vcnt_q + VW'(1);
            end
          end else begin
            vcnt_d = '0;
            if (seed_ok) begin
              hist_d = seed;
            end else begin
              state_d = StSearch;
            end
          end
        end
        StLocked: begin
          // Free-run from the prediction so a corrupted word never poisons later words.
          hist_d = gen_h;
          if (ecnt != '0) begin
            err_d   = 1'b1;
            err_hit = 1'b1;
            if (ccnt_q == CW'(UNLOCK_ERR - 1)) begin
              state_d = StSearch;
              ccnt_d  = '0;
              unlock  = 1'b1;
            end else begin
              ccnt_d = ccnt_q + CW'(1);
            end
          end else begin
            ccnt_d = '0;
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  assign e_eff   = err_hit ? ecnt : '0;
  assign bit_sum = {1'b0, bit_q} + {{(CNT_W + 1 - EW){1'b0}}, e_eff};

  // A clear still records the word sampled in the same cycle.
  always_comb begin
    if (clr_cnt) begin
      bit_d  = CNT_W'(e_eff);
      word_d = CNT_W'(err_hit);
      loss_d = 16'(unlock);
    end else begin
      bit_d  = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
      word_d = (err_hit && (word_q != '1)) ? word_q + CNT_W'(1) : word_q;
      loss_d = (unlock && (loss_q != '1)) ? loss_q + 16'd1 : loss_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StSearch;
      hist_q  <= '0;
      vcnt_q  <= '0;
      ccnt_q  <= '0;
      err_q   <= 1'b0;
      bit_q   <= '0;
      word_q  <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      vcnt_q  <= vcnt_d;
      ccnt_q  <= ccnt_d;
      err_q   <= err_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      loss_q  <= loss_d;
    end
  end

  assign locked        = (state_q == StLocked);
  assign err_word      = err_q;
  assign bit_err_cnt   = bit_q;
  assign word_err_cnt  = word_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_sfp_prbs_checker.sv
// Scoreboard bench for sfp_prbs_checker: bit-serial PRBS31 source, expectations queued per word.
module tb_sfp_prbs_checker;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked;
  logic        err_word;
  logic [31:0] bit_err_cnt;
  logic [31:0] word_err_cnt;
  logic [15:0] lock_loss_cnt;

  sfp_prbs_checker dut (
    .clk          (clk),
    .resetn       (resetn),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .clr_cnt      (clr_cnt),
    .locked       (locked),
    .err_word     (err_word),
    .bit_err_cnt  (bit_err_cnt),
    .word_err_cnt (word_err_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        lk;
    logic        ew;
    logic [31:0] bc;
    logic [31:0] wc;
    logic [15:0] lc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [30:0] sr = 31'h2AAA5555;
  logic        exp_lk = 1'b0;
  logic [31:0] exp_b = '0;
  logic [31:0] exp_w = '0;
  logic [15:0] exp_l = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Serial reference source: sr[0] is the oldest bit, word bit 0 goes out first.
  task automatic gen(output logic [31:0] w);
    logic nb;
    for (int i = 0; i < 32; i++) begin
      nb   = sr[0] ^ sr[3];
      w[i] = nb;
      sr   = {nb, sr[30:1]};
    end
  endtask

  task automatic step(input logic [31:0] d, input logic v, input logic c, input logic ee);
    exp_t e;
    exp_t x;
    e.lk = exp_lk;
    e.ew = ee;
    e.bc = exp_b;
    e.wc = exp_w;
    e.lc = exp_l;
    rx_data  = d;
    rx_valid = v;
    clr_cnt  = c;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check_eq("locked", locked, x.lk);
    check_eq("err_word", err_word, x.ew);
    check_eq("bit_err_cnt", bit_err_cnt, x.bc);
    check_eq("word_err_cnt", word_err_cnt, x.wc);
    check_eq("lock_loss_cnt", lock_loss_cnt, x.lc);
  endtask

  task automatic do_reset(input string tag);
    resetn = 1'b0;
    #1;
    check_eq({tag, "_locked"}, locked, 0);
    check_eq({tag, "_err_word"}, err_word, 0);
    check_eq({tag, "_bit_cnt"}, bit_err_cnt, 0);
    check_eq({tag, "_word_cnt"}, word_err_cnt, 0);
    check_eq({tag, "_loss_cnt"}, lock_loss_cnt, 0);
    rx_valid = 1'b0;
    clr_cnt  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq({tag, "_held_locked"}, locked, 0);
    resetn = 1'b1;
    exp_lk = 1'b0;
    exp_b  = '0;
    exp_w  = '0;
    exp_l  = '0;
  endtask

  initial begin
    logic [31:0] w;
    #2;
    do_reset("rst0");

    // Clean stream: lock after seed + 64 verified words, then 1000 clean words.
    for (int k = 1; k <= 1065; k++) begin
      gen(w);
      exp_lk = (k >= 65);
      step(w, 1'b1, 1'b0, 1'b0);
    end

    // Single bit error, an idle cycle with garbage, then a clean word.
    gen(w);
    exp_b = 1;
    exp_w = 1;
    step(w ^ 32'h20, 1'b1, 1'b0, 1'b1);
    step($urandom, 1'b0, 1'b0, 1'b0);
    gen(w);
    step(w, 1'b1, 1'b0, 1'b0);

    // Three-bit error together with a clear.
    gen(w);
    exp_b = 3;
    exp_w = 1;
    step(w ^ 32'h8000_0081, 1'b1, 1'b1, 1'b1);
    gen(w);
    step(w, 1'b1, 1'b0, 1'b0);

    // 16 inverted words (clear on the first) force loss of lock.
    for (int i = 1; i <= 16; i++) begin
      gen(w);
      exp_b = 32 * i;
      exp_w = i;
      if (i == 16) begin
        exp_lk = 1'b0;
        exp_l  = 1;
      end
      step(~w, 1'b1, (i == 1), 1'b1);
    end
    for (int k = 1; k <= 65; k++) begin
      gen(w);
      exp_lk = (k == 65);
      step(w, 1'b1, 1'b0, 1'b0);
    end

    do_reset("rst_locked");

    // Alternating rx_valid: only valid words count toward lock.
    for (int k = 1; k <= 65; k++) begin
      gen(w);
      exp_lk = (k == 65);
      step(w, 1'b1, 1'b0, 1'b0);
      step($urandom, 1'b0, 1'b0, 1'b0);
    end

    // Dead link: every predicted one counts as an error until lock drops.
    for (int i = 1; i <= 16; i++) begin
      gen(w);
      exp_b = exp_b + 32'($countones(w));
      exp_w = i;
      if (i == 16) begin
        exp_lk = 1'b0;
        exp_l  = 1;
      end
      step('0, 1'b1, 1'b0, 1'b1);
    end
    for (int k = 0; k < 70; k++) begin
      step('0, 1'b1, 1'b0, 1'b0);
    end

    do_reset("rst1");

    // Error at verify word 10 restarts the lock count from that word.
    for (int k = 0; k < 80; k++) begin
      gen(w);
      if (k == 10) w = w ^ 32'h1;
      exp_lk = (k >= 74);
      step(w, 1'b1, 1'b0, 1'b0);
    end
    gen(w);
    exp_b = 1;
    exp_w = 1;
    step(w ^ 32'h100, 1'b1, 1'b0, 1'b1);
    gen(w);
    rx_data  = w ^ 32'h1;
    rx_valid = 1'b1;
    do_reset("rst_mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sfp_prbs_checker.md
Name: sfp_prbs_checker

Overview:
- Receive-side partner of the SFP0 LFSR pattern generator (gth_driver): checks the PRBS31 stream coming back on SFP0 RX.
- Takes the parallel word from the GTH RX user interface, self-synchronises to the pattern, then counts bit and word errors.
- Instanced in system_top next to gth_driver on the GTH RX user clock. Lock status and counters are exported to GPIO inputs for the loopback/fiber link test without the classical NIC.

Parameters:
- DATA_W, 32: RX parallel word width; legal values 32 or 64; must be >= PRBS_LEN.
- PRBS_LEN, 31: LFSR length; recurrence is b[n] = b[n-PRBS_LEN] ^ b[n-PRBS_TAP].
- PRBS_TAP, 28: second tap of the recurrence.
- LOCK_CNT, 64: consecutive matching words required after the seed word to declare lock.
- UNLOCK_ERR, 16: consecutive errored words while locked that force loss of lock.
- CNT_W, 32: width of the error counters.

Ports:
- clk  in  1  GTH RX user clock; all logic is in this single clock domain.
- resetn  in  1  asynchronous, active-low reset.
- rx_data  in  DATA_W  received word; bit 0 is the earliest bit in time.
- rx_valid  in  1  rx_data is valid this cycle.
- clr_cnt  in  1  synchronous clear of the error counters.
- locked  out  1  checker is locked to the pattern.
- err_word  out  1  one-cycle pulse per errored word while locked.
- bit_err_cnt  out  CNT_W  saturating count of errored bits.
- word_err_cnt  out  CNT_W  saturating count of errored words.
- lock_loss_cnt  out  16  saturating count of LOCKED-to-SEARCH transitions.

Behaviour:
- Reset values: every output is 0; FSM = SEARCH; all internal counters 0. Reset asserted mid-operation clears all of these immediately (asynchronous).
- Word k carries b[k*DATA_W+i] at bit i.
- pred = next DATA_W bits generated from the 31-bit history register (hist); the generation is combinational.
- All FSM activity below happens only on cycles with rx_valid=1. Cycles with rx_valid=0 change no state, no count and produce no pulse.
- SEARCH:
  - A nonzero word seeds the checker: hist <= top PRBS_LEN bits of rx_data, vcnt <= 0, FSM -> VERIFY.
  - An all-zero word is rejected and the FSM stays in SEARCH (prevents locking onto a dead link).
- VERIFY:
  - rx_data == pred: vcnt increments and hist advances.
  - When vcnt reaches LOCK_CNT, FSM -> LOCKED and locked=1 on the following cycle.
  - Mismatch: reseed from rx_data as in SEARCH (all-zero word -> SEARCH) and set vcnt=0.
  - No error counting takes place in VERIFY.
- LOCKED:
  - hist advances from pred, never from rx_data, so a single error does not propagate into later predictions.
  - e = popcount(rx_data ^ pred).
  - If e > 0: err_word=1 for exactly the next cycle; bit_err_cnt += e; word_err_cnt += 1; ccnt += 1.
  - If e == 0: ccnt <= 0.
  - When ccnt reaches UNLOCK_ERR: FSM -> SEARCH, locked=0 on the next cycle, lock_loss_cnt += 1. bit and word counters keep their values.
- Counters saturate at all-ones; saturation never wraps to 0.
- clr_cnt=1 has priority:
  - bit_err_cnt <= e and word_err_cnt <= (e>0) for the word sampled that same cycle, so that word's errors are not lost.
  - lock_loss_cnt <= 1 if an unlock occurs that cycle, else 0.
  - clr_cnt does not affect the FSM or locked.
- Latency: outputs are registered, one cycle after the rx_valid edge. popcount is single-cycle combinational; it must meet timing at 312.5 MHz with DATA_W=32.

Test Plan:
- Clean PRBS31 stream, rx_valid=1 every cycle after reset release -> locked rises on the cycle after word 65 (seed + 64 verified); all counters stay 0 for 1000 further words.
- Locked; flip bit 5 of word 200 -> err_word high for exactly 1 cycle; bit_err_cnt=1, word_err_cnt=1; word 201 is error-free; locked stays 1.
- Locked; flip 3 bits in one word and assert clr_cnt on that same cycle -> bit_err_cnt=3, word_err_cnt=1.
- Locked; invert 16 consecutive words -> locked falls the cycle after the 16th word, lock_loss_cnt=1, word_err_cnt=16, bit_err_cnt=512. Then 65 clean words -> relock.
- rx_valid toggling 1/0 on a clean stream -> locked after 65 valid words (about 130 cycles) with no errors. Then all-zero input -> locked drops after 16 words and the FSM stays in SEARCH.
- Single-bit error at verify word 10 -> no lock at word 65; lock on the cycle after word 10+65 counted from the reseed; counters stay 0. Drop resetn while locked -> all outputs 0 immediately.
